// File: rtl/mcpu_mem_pkg.sv
// Shared types and constants for the MCPU memory Avalon responder.
package mcpu_mem_pkg;

  localparam int AVL_DATA_W = 128;
  localparam int AVL_ADDR_W = 25;
  localparam int AVL_BE_W   = 16;
  localparam int AVL_SIZE_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WBURST,
    ST_RWAIT,
    ST_RDATA
  } mem_state_e;

  // A zero burst length means a single beat.
  function automatic logic [AVL_SIZE_W-1:0] norm_size(input logic [AVL_SIZE_W-1:0] s);
    return (s == '0) ? AVL_SIZE_W'(1) : s;
  endfunction

endpackage

// File: rtl/mcpu_mem_avl_ram.sv
// Single-port backing store: byte-enable writes, one-cycle registered read.
module mcpu_mem_avl_ram
  import mcpu_mem_pkg::*;
#(
  parameter int ADDR_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_LOG2-1:0]  i_addr,
  input  logic [AVL_BE_W-1:0]   i_be,
  input  logic [AVL_DATA_W-1:0] i_wdata,
  output logic [AVL_DATA_W-1:0] o_rdata
);

  logic [AVL_DATA_W-1:0] r_mem [2**ADDR_LOG2];
  logic [AVL_DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < AVL_BE_W; b++) begin
        if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/mcpu_mem_avl_resp.sv
// Avalon burst responder over a byte-enable RAM; read data is issued one
// cycle early so the RAM's registered read lands exactly RD_LAT after accept.
module mcpu_mem_avl_resp
  import mcpu_mem_pkg::*;
#(
  parameter int ADDR_LOG2 = 10,
  parameter int RD_LAT    = 4
) (
  input  logic                  clkrst_mem_clk,
  input  logic                  clkrst_mem_rst,
  input  logic [AVL_ADDR_W-1:0] ltc2mc_avl_addr_0,
  input  logic [AVL_BE_W-1:0]   ltc2mc_avl_be_0,
  input  logic                  ltc2mc_avl_burstbegin_0,
  input  logic                  ltc2mc_avl_read_req_0,
  input  logic [AVL_SIZE_W-1:0] ltc2mc_avl_size_0,
  input  logic [AVL_DATA_W-1:0] ltc2mc_avl_wdata_0,
  input  logic                  ltc2mc_avl_write_req_0,
  output logic                  ltc2mc_avl_ready_0,
  output logic [AVL_DATA_W-1:0] ltc2mc_avl_rdata_0,
  output logic                  ltc2mc_avl_rdata_valid_0,
  output logic                  proto_err
);

  localparam int AW = ADDR_LOG2;
  // RWAIT residency when the RAM read is issued the cycle before valid.
  localparam logic [3:0] WAIT_INIT = 4'((RD_LAT >= 3) ? RD_LAT - 3 : 0);

  mem_state_e            r_state, w_nstate;
  logic                  r_live, r_vld, r_perr;
  logic [AW-1:0]         r_addr, w_addr_nxt;
  logic [AVL_SIZE_W-1:0] r_left, w_left_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;

  logic                  w_ready, w_wr, w_rd, w_we, w_re, w_perr_set;
  logic [AW-1:0]         w_in_addr, w_ram_addr;
  logic [AVL_SIZE_W-1:0] w_in_size;
  logic [AVL_DATA_W-1:0] w_ram_q;
  logic                  w_unused_addr;

  assign w_in_addr     = ltc2mc_avl_addr_0[AW-1:0];
  assign w_unused_addr = ^ltc2mc_avl_addr_0[AVL_ADDR_W-1:AW];
  assign w_in_size     = norm_size(ltc2mc_avl_size_0);

  assign w_ready = r_live & ~r_vld & ((r_state == ST_IDLE) | (r_state == ST_WBURST));
  assign w_wr    = ltc2mc_avl_write_req_0 & w_ready;
  assign w_rd    = ltc2mc_avl_read_req_0 & ~ltc2mc_avl_write_req_0 & w_ready;

  always_comb begin
    w_nstate   = r_state;
    w_addr_nxt = r_addr;
    w_left_nxt = r_left;
    w_cnt_nxt  = r_cnt;
    w_we       = 1'b0;
    w_re       = 1'b0;
    w_ram_addr = r_addr;
    w_perr_set = w_ready & ltc2mc_avl_read_req_0 & ltc2mc_avl_write_req_0;
    case (r_state)
      ST_IDLE, ST_WBURST: begin
        if (w_wr) begin
          if (ltc2mc_avl_burstbegin_0) begin
            w_perr_set = w_perr_set | (r_state == ST_WBURST);
            w_we       = 1'b1;
            w_ram_addr = w_in_addr;
            w_addr_nxt = w_in_addr + AW'(1);
            w_left_nxt = w_in_size - AVL_SIZE_W'(1);
            w_nstate   = (w_in_size > AVL_SIZE_W'(1)) ? ST_WBURST : ST_IDLE;
          end else if (r_state == ST_WBURST) begin
            w_we       = 1'b1;
            w_addr_nxt = r_addr + AW'(1);
            w_left_nxt = r_left - AVL_SIZE_W'(1);
            if (r_left == AVL_SIZE_W'(1)) w_nstate = ST_IDLE;
          end else begin
            w_perr_set = 1'b1;
          end
        end else if (w_rd) begin
          if (r_state == ST_WBURST) begin
            w_perr_set = 1'b1;
          end else if (ltc2mc_avl_burstbegin_0) begin
            if (RD_LAT <= 1) begin
              w_re       = 1'b1;
              w_ram_addr = w_in_addr;
              w_addr_nxt = w_in_addr + AW'(1);
              w_left_nxt = w_in_size - AVL_SIZE_W'(1);
              w_nstate   = (w_in_size > AVL_SIZE_W'(1)) ? ST_RDATA : ST_IDLE;
            end else begin
              w_addr_nxt = w_in_addr;
              w_left_nxt = w_in_size;
              w_cnt_nxt  = WAIT_INIT;
              w_nstate   = (RD_LAT == 2) ? ST_RDATA : ST_RWAIT;
            end
          end
        end
      end
      ST_RWAIT: begin
        if (r_cnt == 4'd0) w_nstate = ST_RDATA;
        else               w_cnt_nxt = r_cnt - 4'd1;
      end
      ST_RDATA: begin
        w_re       = 1'b1;
        w_addr_nxt = r_addr + AW'(1);
        w_left_nxt = r_left - AVL_SIZE_W'(1);
        if (r_left == AVL_SIZE_W'(1)) w_nstate = ST_IDLE;
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      r_state <= ST_IDLE;
      r_live  <= 1'b0;
      r_vld   <= 1'b0;
      r_perr  <= 1'b0;
      r_addr  <= '0;
      r_left  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_live  <= 1'b1;
      r_vld   <= w_re;
      r_perr  <= r_perr | w_perr_set;
      r_addr  <= w_addr_nxt;
      r_left  <= w_left_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  mcpu_mem_avl_ram #(.ADDR_LOG2(AW)) u_ram (
    .clk     (clkrst_mem_clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_ram_addr),
    .i_be    (ltc2mc_avl_be_0),
    .i_wdata (ltc2mc_avl_wdata_0),
    .o_rdata (w_ram_q)
  );

  assign ltc2mc_avl_ready_0       = w_ready;
  assign ltc2mc_avl_rdata_valid_0 = r_vld;
  assign ltc2mc_avl_rdata_0       = r_vld ? w_ram_q : '0;
  assign proto_err                = r_perr;

endmodule

// File: tb/tb_mcpu_mem_avl_resp.sv
// Randomized bench for mcpu_mem_avl_resp with a cycle-labelled reference model.
module tb_mcpu_mem_avl_resp;
  localparam int AL = 10, RL = 4, DEPTH = 1 << AL;

  logic         clk = 1'b0, rst = 1'b1;
  logic [24:0]  addr = '0;
  logic [15:0]  be = '0;
  logic         bb = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [4:0]   size = '0;
  logic [127:0] wdata = '0;
  logic         ready, rvalid, perr;
  logic [127:0] rdata;

  always #5 clk = ~clk;

  mcpu_mem_avl_resp #(.ADDR_LOG2(AL), .RD_LAT(RL)) dut (
    .clkrst_mem_clk          (clk),
    .clkrst_mem_rst          (rst),
    .ltc2mc_avl_addr_0       (addr),
    .ltc2mc_avl_be_0         (be),
    .ltc2mc_avl_burstbegin_0 (bb),
    .ltc2mc_avl_read_req_0   (rd),
    .ltc2mc_avl_size_0       (size),
    .ltc2mc_avl_wdata_0      (wdata),
    .ltc2mc_avl_write_req_0  (wr),
    .ltc2mc_avl_ready_0      (ready),
    .ltc2mc_avl_rdata_0      (rdata),
    .ltc2mc_avl_rdata_valid_0(rvalid),
    .proto_err               (perr)
  );

  int checks = 0, fails = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each cycle has a label (edge count); a read accepted in
  // cycle a yields beats in cycles a+RL .. a+RL+n-1 with data snapshotted at accept.
  typedef struct { longint lbl; logic [127:0] d; } beat_t;
  beat_t        m_q[$];
  logic [127:0] m_mem [DEPTH];
  bit           m_live = 0, m_perr = 0;
  int           m_wleft = 0;
  logic [AL-1:0] m_waddr = '0;
  longint       ec = 0, m_busy_end = -1;

  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

  function automatic void m_write(input logic [AL-1:0] a, input logic [15:0] e, input logic [127:0] d);
    for (int b = 0; b < 16; b++) if (e[b]) m_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  always @(posedge clk) begin : model
    int sz;
    logic [AL-1:0] a, ai;
    if (rst) begin
      m_live = 0; m_perr = 0; m_wleft = 0; m_busy_end = -1;
      m_q.delete();
    end else begin
      if (m_live && ec > m_busy_end) begin
        sz = (size == 0) ? 1 : int'(size);
        a  = addr[AL-1:0];
        if (wr && rd) m_perr = 1;
        if (wr) begin
          if (bb) begin
            if (m_wleft > 0) m_perr = 1;
            m_write(a, be, wdata);
            m_waddr = a + AL'(1);
            m_wleft = sz - 1;
          end else if (m_wleft > 0) begin
            m_write(m_waddr, be, wdata);
            m_waddr = m_waddr + AL'(1);
            m_wleft--;
          end else m_perr = 1;
        end else if (rd) begin
          if (m_wleft > 0) m_perr = 1;
          else if (bb) begin
            for (int i = 0; i < sz; i++) begin
              ai = a + AL'(i);
              m_q.push_back('{ec + RL + i, m_mem[ai]});
            end
            m_busy_end = ec + RL + sz - 1;
          end
        end
      end
      m_live = 1;
    end
    ec++;
    while (m_q.size() > 0 && m_q[0].lbl < ec) void'(m_q.pop_front());
  end

  always @(negedge clk) begin : cmp
    logic ev, er, ep;
    logic [127:0] ed;
    er = !rst && m_live && (ec > m_busy_end);
    ev = !rst && m_q.size() > 0 && m_q[0].lbl == ec;
    ed = ev ? m_q[0].d : '0;
    ep = !rst && m_perr;
    chk("ready", ready, er);
    chk("rdata_valid", rvalid, ev);
    chk("rdata", rdata, ed);
    chk("proto_err", perr, ep);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic r, input logic w, input logic b, input logic [24:0] a,
                      input logic [4:0] s, input logic [15:0] e, input logic [127:0] d,
                      output int waited);
    waited = 0;
    rd = r; wr = w; bb = b; addr = a; size = s; be = e; wdata = d;
    @(negedge clk);
    while (!ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 200) begin
      checks++; fails++;
      $display("FAIL send_timeout actual=ready_low required=ready_high t=%0t", $time);
    end
    @(posedge clk); #1;
    rd = 0; wr = 0; bb = 0;
  endtask

  logic [127:0] got[$];
  int got_first;

  task automatic collect(input int ncyc);
    got.delete();
    got_first = -1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (rvalid) begin
        if (got_first < 0) got_first = i;
        got.push_back(rdata);
      end
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : drive
    int w;
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    wait_cyc(3);
    @(negedge clk);
    chk("reset_ready", ready, 0);
    @(posedge clk); #1;
    rst = 0;
    wait_cyc(1);
    chk("ready_after_reset", ready, 1);

    for (int blk = 0; blk < DEPTH / 16; blk++)
      for (int i = 0; i < 16; i++)
        send(0, 1, i == 0, 25'(blk * 16), 5'd16, 16'hFFFF, '0, w);

    // Single write then single read
    send(0, 1, 1, 25'h5, 5'd1, 16'hFFFF, a5, w);
    send(1, 0, 1, 25'h5, 5'd1, 16'h0, '0, w);
    collect(10);
    chk("single_latency", 128'(got_first), 128'(RL - 1));
    chk("single_count", 128'(got.size()), 1);
    if (got.size() > 0) chk("single_data", got[0], a5);

    // Partial byte-enable write over zero
    send(0, 1, 1, 25'h10, 5'd1, 16'h000F, '1, w);
    send(1, 0, 1, 25'h10, 5'd1, 16'h0, '0, w);
    collect(10);
    if (got.size() > 0) chk("partial_data", got[0], 128'hFFFF_FFFF);
    else chk("partial_count", 0, 1);

    // Burst wrapping past the top of the store
    for (int i = 0; i < 4; i++) send(0, 1, i == 0, 25'h3FE, 5'd4, 16'hFFFF, 128'(i + 1), w);
    send(1, 0, 1, 25'h3FE, 5'd4, 16'h0, '0, w);
    collect(12);
    chk("wrap_count", 128'(got.size()), 4);
    for (int i = 0; i < got.size() && i < 4; i++) chk("wrap_beat", got[i], 128'(i + 1));
    send(1, 0, 1, 25'h1000000, 5'd0, 16'h0, '0, w);
    collect(10);
    if (got.size() > 0) chk("wrap_addr0", got[0], 128'd3);
    else chk("wrap_addr0_count", 0, 1);

    // Backpressure: write held off until a 16-beat read finishes
    send(1, 0, 1, 25'h0, 5'd16, 16'h0, '0, w);
    send(0, 1, 1, 25'h20, 5'd1, 16'hFFFF, 128'h77, w);
    chk("backpressure_wait", 128'(w), 128'(RL + 15));

    // Reset during the second beat of an 8-beat read
    send(1, 0, 1, 25'h3FE, 5'd8, 16'h0, '0, w);
    wait_cyc(RL - 1);
    @(negedge clk);
    chk("rst_beat1_valid", rvalid, 1);
    @(posedge clk); #1;
    rst = 1; #1;
    chk("rst_valid_drop", rvalid, 0);
    chk("rst_rdata_zero", rdata, 0);
    wait_cyc(2);
    rst = 0;
    wait_cyc(1);
    chk("rst_ready_back", ready, 1);
    send(1, 0, 1, 25'h3FF, 5'd1, 16'h0, '0, w);
    collect(10);
    if (got.size() > 0) chk("rst_data_kept", got[0], 128'd2);
    else chk("rst_data_count", 0, 1);

    // Protocol errors
    send(1, 1, 1, 25'h30, 5'd1, 16'hFFFF, 128'h1234_5678, w);
    @(negedge clk);
    chk("rdwr_perr", perr, 1);
    @(posedge clk); #1;
    send(1, 0, 1, 25'h30, 5'd1, 16'h0, '0, w);
    collect(10);
    if (got.size() > 0) chk("rdwr_data", got[0], 128'h1234_5678);
    else chk("rdwr_count", 0, 1);
    rst = 1; wait_cyc(2); rst = 0; wait_cyc(1);
    chk("perr_cleared", perr, 0);
    send(0, 1, 0, 25'h31, 5'd1, 16'hFFFF, '1, w);
    @(negedge clk);
    chk("nobb_perr", perr, 1);
    @(posedge clk); #1;
    send(1, 0, 1, 25'h31, 5'd1, 16'h0, '0, w);
    collect(10);
    if (got.size() > 0) chk("nobb_unchanged", got[0], 0);
    else chk("nobb_count", 0, 1);

    // Randomized traffic, checked every cycle by the model
    for (int op = 0; op < 250; op++) begin
      int k, n;
      logic [4:0] sz;
      logic [24:0] ra;
      k  = $urandom_range(0, 9);
      sz = 5'($urandom_range(0, 16));
      ra = 25'($urandom);
      n  = (sz == 0) ? 1 : int'(sz);
      if (k <= 4) begin
        for (int i = 0; i < n; i++) begin
          if (i > 0 && $urandom_range(0, 19) == 0)
            send(1, 0, 1, 25'($urandom), 5'($urandom_range(1, 4)), 16'h0, '0, w);
          send($urandom_range(0, 19) == 0, 1, (i == 0) || ($urandom_range(0, 19) == 0),
               ra, sz, 16'($urandom), r128(), w);
        end
      end else if (k <= 8) begin
        send(1, 0, 1, ra, sz, 16'h0, '0, w);
      end else begin
        send(0, 1, 0, ra, sz, 16'hFFFF, r128(), w);
      end
      wait_cyc($urandom_range(0, 2));
    end
    wait_cyc(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/mcpu_mem_avl_resp.md
MCPU_MEM_AVL_RESP -- requirements
Module: MCPU_mem_avl_resp

Interface
REQ-001 SHALL have parameter ADDR_LOG2, default 10: backing store holds 2^ADDR_LOG2 128-bit words.
REQ-002 SHALL have parameter RD_LAT, default 4, legal 1..15: cycles from read accept to first rdata_valid.
REQ-003 clkrst_mem_clk  in  1  sole clock; all logic on the rising edge.
REQ-004 clkrst_mem_rst  in  1  asynchronous, active-high reset.
REQ-005 ltc2mc_avl_addr_0  in  25  word address, sampled on the first beat.
REQ-006 ltc2mc_avl_be_0  in  16  byte enables, one per byte of wdata, per beat.
REQ-007 ltc2mc_avl_burstbegin_0  in  1  marks the first beat of a burst.
REQ-008 ltc2mc_avl_read_req_0  in  1  read request.
REQ-009 ltc2mc_avl_size_0  in  5  burst length in beats, 1..16; 0 is treated as 1.
REQ-010 ltc2mc_avl_wdata_0  in  128  write data.
REQ-011 ltc2mc_avl_write_req_0  in  1  write request, one per beat.
REQ-012 ltc2mc_avl_ready_0  out  1  responder can accept a request or beat this cycle.
REQ-013 ltc2mc_avl_rdata_0  out  128  read data.
REQ-014 ltc2mc_avl_rdata_valid_0  out  1  rdata holds a valid beat.
REQ-015 proto_err  out  1  sticky protocol-violation flag.

Function
REQ-016 A transfer SHALL occur only on a cycle where (read_req or write_req) and ready are both 1.
REQ-017 FSM states: IDLE, WBURST, RWAIT, RDATA.
REQ-018 IDLE: ready=1. Write with burstbegin -> write beat 0 at addr, latch addr+1 and size; go to WBURST if size>1, else stay in IDLE.
REQ-019 WBURST: ready=1. Each write beat goes to the latched address, which then increments; after the last beat, go to IDLE.
REQ-020 A write SHALL update only bytes whose be bit is 1; other bytes keep their value.
REQ-021 IDLE read with burstbegin: latch addr and size; go to RWAIT; ready=0 from the next cycle until the response completes.
REQ-022 RWAIT SHALL count RD_LAT-1 cycles, then go to RDATA, so the first rdata_valid falls exactly RD_LAT cycles after the accept cycle.
REQ-023 RDATA SHALL assert rdata_valid for size consecutive cycles with addr, addr+1, ...; after the last beat, go to IDLE; ready returns to 1 on the cycle after the last beat.
REQ-024 Addresses SHALL wrap modulo 2^ADDR_LOG2; upper address bits SHALL be ignored.
REQ-025 A beat's address SHALL also wrap within the store, with no boundary error.
REQ-026 read_req and write_req both 1 while ready: write wins, read is dropped, proto_err set.
REQ-027 write_req without burstbegin in IDLE: beat ignored, proto_err set.
REQ-028 burstbegin during WBURST: proto_err set; the current burst is abandoned and a new burst starts per REQ-018.
REQ-029 read_req during WBURST: ignored, proto_err set.
REQ-030 Read data SHALL reflect all writes accepted before the read accept cycle.
REQ-031 rdata SHALL be 0 whenever rdata_valid=0.

Reset
REQ-032 While clkrst_mem_rst=1, outputs SHALL be: ready=0, rdata_valid=0, rdata=0, proto_err=0; FSM SHALL be IDLE.
REQ-033 ready=1 SHALL be driven from the first clock edge after reset deasserts.
REQ-034 Reset mid-burst SHALL abort the burst with no further rdata_valid; store contents are not reset.
REQ-035 proto_err SHALL clear only on reset.

Structure
REQ-036 A shared package (MCPU_mem_pkg) SHALL hold: the FSM state enum; constants AVL_DATA_W=128, AVL_ADDR_W=25, AVL_BE_W=16, AVL_SIZE_W=5.
REQ-037 One sub-module, MCPU_mem_avl_ram: single-port 128-bit RAM with byte-enable writes and a 1-cycle registered read. The latency counter SHALL compensate so REQ-022 holds.

Verification
REQ-038 Single write: addr=0x5, size=1, be=0xFFFF, data=0xA5..A5; then read addr=0x5, size=1 -> rdata_valid exactly 4 cycles after accept, rdata=0xA5..A5.
REQ-039 Partial write: be=0x000F, data=all-1s over a word of 0 -> read returns 0x0000_..._FFFF_FFFF.
REQ-040 Burst wrap: write size=4 at addr=0x3FE (ADDR_LOG2=10) with data 1,2,3,4 -> read size=4 at 0x3FE returns 1,2,3,4 on 4 consecutive cycles, and addr 0x000 holds 3.
REQ-041 Backpressure: read size=16 -> ready=0 from the cycle after accept through the 16th valid beat, then ready=1; a write_req presented meanwhile is not accepted until ready=1.
REQ-042 Protocol errors: read_req and write_req together -> write performed, proto_err=1; write without burstbegin in IDLE -> no store change, proto_err=1.
REQ-043 Reset at the 2nd beat of an 8-beat read -> rdata_valid=0 immediately; after reset, ready=1 and earlier written data is still present.
